// File: rtl/prio_sched_pkg.sv
// Shared types and helpers for the priority mux scheduler.
package prio_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } sched_state_e;

  // out_src value that marks the late override as the source
  function automatic int src_late(input int n);
    return n;
  endfunction

  function automatic int src_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/prio_mux_sched_pick.sv
// Lowest-index one-hot priority encoder.
module prio_pick #(
  parameter int W = 6
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] onehot,
  output logic         any
);

  // two's-complement trick isolates the lowest set bit
  assign onehot = req & (~req + W'(1));
  assign any    = |req;

endmodule

// File: rtl/prio_mux_sched.sv
// Registered priority scheduler: N requesters plus a late override share one output lane.
// Starvation aging is present only when PRIO_SCHED_AGING_EN is defined.
//
// state | meaning
// IDLE  | output register empty, out_valid=0
// FULL  | output register holds an item, out_valid=1
module prio_mux_sched
  import prio_sched_pkg::*;
#(
  parameter int N       = 6,
  parameter int DW      = 8,
  parameter int AGE_MAX = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      data,
  input  logic                 late_req,
  input  logic [DW-1:0]        late_data,
  output logic [N-1:0]         gnt,
  output logic                 late_gnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [src_w(N)-1:0]  out_src
);

  localparam int SW = src_w(N);
  localparam logic [SW-1:0] SRC_LATE = SW'(src_late(N));

  if (AGE_MAX < 1) begin : g_bad_age_max
    $error("AGE_MAX must be >= 1");
  end

  sched_state_e  state_q, state_d;
  logic [N-1:0]  starved, starve_oh, req_oh, pre_oh;
  logic          any_starved, any_req, sel_late, load;
  logic [SW-1:0] pre_idx;
  logic [DW-1:0] pre_data;

`ifdef PRIO_SCHED_AGING_EN
  localparam int AW = $clog2(AGE_MAX + 1);
  logic [AW-1:0] age_q [N];

  always_comb begin
    starved = '0;
    for (int i = 0; i < N; i++) starved[i] = req[i] && (age_q[i] == AW'(AGE_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || gnt[i]) age_q[i] <= '0;
        else if (load && age_q[i] != AW'(AGE_MAX)) age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end
`else
  assign starved = '0;
`endif

  prio_pick #(.W(N)) u_pick_starved (.req(starved), .onehot(starve_oh), .any(any_starved));
  prio_pick #(.W(N)) u_pick_req     (.req(req),     .onehot(req_oh),    .any(any_req));

  assign pre_oh = any_starved ? starve_oh : req_oh;

  always_comb begin
    pre_idx  = '0;
    pre_data = '0;
    for (int i = 0; i < N; i++) begin
      if (pre_oh[i]) begin
        pre_idx  = SW'(i);
        pre_data = data[i*DW +: DW];
      end
    end
  end

  // late override joins only at the final 2:1 stage
  assign sel_late = late_req && !any_starved;
  assign load     = !rst && (state_q == IDLE || out_ready) && (any_req || late_req);

  always_comb begin
    state_d  = state_q;
    gnt      = '0;
    late_gnt = 1'b0;
    if (load) begin
      gnt      = sel_late ? '0 : pre_oh;
      late_gnt = sel_late;
    end
    case (state_q)
      IDLE:    if (load) state_d = FULL;
      FULL:    if (out_ready && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      out_data <= '0;
      out_src  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_data <= sel_late ? late_data : pre_data;
        out_src  <= sel_late ? SRC_LATE : pre_idx;
      end
    end
  end

  assign out_valid = (state_q == FULL);

endmodule
